// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes shared with the ALU decoder, sequencer state encoding,
// and op classification helpers for the multi-cycle M-extension unit.
package muldiv_pkg;

    localparam int OP_W = 5;

    // M-extension op codes as emitted by the ALU decoder
    localparam logic [OP_W-1:0] OP_MULU   = 5'b01001;
    localparam logic [OP_W-1:0] OP_MULHS  = 5'b01010;
    localparam logic [OP_W-1:0] OP_MULHSU = 5'b01011;
    localparam logic [OP_W-1:0] OP_MULHU  = 5'b01100;
    localparam logic [OP_W-1:0] OP_DIVU   = 5'b01101;
    localparam logic [OP_W-1:0] OP_DIVS   = 5'b01110;
    localparam logic [OP_W-1:0] OP_REMU   = 5'b01111;
    localparam logic [OP_W-1:0] OP_REMS   = 5'b10000;

    // State codes kept as plain constants so legacy tools can match them
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_PREP = S_PREP,
        ST_CALC = S_CALC,
        ST_FIX  = S_FIX,
        ST_DONE = S_DONE
    } state_e;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return (op == OP_MULU) || (op == OP_MULHS) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS) || (op == OP_REMU) || (op == OP_REMS);
    endfunction

    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return (op == OP_REMU) || (op == OP_REMS);
    endfunction

    // Both operands are two's complement (mulhsu is handled separately: only a is signed)
    function automatic logic is_signed(input logic [OP_W-1:0] op);
        return (op == OP_MULHS) || (op == OP_DIVS) || (op == OP_REMS);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer datapath.
// Multiply: shift-add on {hi,lo}, lo holds the multiplier and shifts out LSB first.
// Divide: restoring shift-subtract, hi is the partial remainder and lo the
// dividend that gradually turns into the quotient.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // Single add-and-shift or subtract-and-shift step
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        // Only used when shifted >= opnd, so the difference fits in XLEN bits
        diff    = shifted[XLEN-1:0] - opnd;
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        if (div_mode) begin
            if (shifted >= {1'b0, opnd}) begin
                hi_next = diff;
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer for M-extension ops.
// Runs XLEN iterations of muldiv_step on magnitudes, then fixes signs.
// Optional build macro DIV_ZERO_FAST_EN: divide/remainder by zero completes
// straight from PREP (latency 2) instead of running the full iteration loop.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    state_e          state;
    logic [4:0]      op;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [CW-1:0]   cnt;
    logic            sign_a;
    logic            sign_b;
    logic            b_zero;
    logic [XLEN-1:0] result;

    logic            start_m;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;

    assign start_m = start_i && (is_mul(alu_op_i) || is_div(alu_op_i));

    // Operand sign capture and magnitude conversion used in PREP
    always_comb begin
        neg_a = a_reg[XLEN-1] && (is_signed(op) || (op == OP_MULHSU));
        neg_b = b_reg[XLEN-1] && is_signed(op);
        a_abs = neg_a ? (~a_reg + 1'b1) : a_reg;
        b_abs = neg_b ? (~b_reg + 1'b1) : b_reg;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(op)),
        .hi       (hi),
        .lo       (lo),
        .opnd     (opnd),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // Sign restoration and result selection used in FIX
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~{hi, lo} + 1'b1) : {hi, lo};
        quo_fix  = ((sign_a ^ sign_b) && !b_zero) ? (~lo + 1'b1) : lo;
        rem_fix  = sign_a ? (~hi + 1'b1) : hi;
        if (is_mul(op)) begin
            fix_result = (op == OP_MULU) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fix_result = is_rem(op) ? rem_fix : quo_fix;
        end
    end

    // Sequencer FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            op     <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            result <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_m) begin
                        op    <= alu_op_i;
                        a_reg <= a_i;
                        b_reg <= b_i;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    b_zero <= (b_reg == '0);
                    cnt    <= CW'(XLEN - 1);
                    hi     <= '0;
                    if (is_div(op)) begin
                        lo   <= a_abs;
                        opnd <= b_abs;
                    end else begin
                        lo   <= b_abs;
                        opnd <= a_abs;
                    end
                    state <= ST_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (is_div(op) && (b_reg == '0)) begin
                        result <= is_rem(op) ? a_reg : '1;
                        state  <= ST_DONE;
                    end
`endif
                end
                ST_CALC: begin
                    hi <= hi_next;
                    lo <= lo_next;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    result <= fix_result;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs; stall is held low while reset is asserted
    always_comb begin
        busy_o   = (state != ST_IDLE);
        done_o   = (state == ST_DONE);
        stall_o  = rst && (((state == ST_IDLE) && start_m) || (state == ST_PREP) ||
                           (state == ST_CALC) || (state == ST_FIX));
        result_o = result;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table, hand-written multi-cycle sequences
// (flush, non-M op, reset mid-operation) and random ops against an arithmetic model.
module tb_muldiv_seq;

    localparam logic [4:0] T_MULU   = 5'b01001;
    localparam logic [4:0] T_MULHS  = 5'b01010;
    localparam logic [4:0] T_MULHSU = 5'b01011;
    localparam logic [4:0] T_MULHU  = 5'b01100;
    localparam logic [4:0] T_DIVU   = 5'b01101;
    localparam logic [4:0] T_DIVS   = 5'b01110;
    localparam logic [4:0] T_REMU   = 5'b01111;
    localparam logic [4:0] T_REMS   = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  alu_op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int ia = a;
        int ib = b;
        longint sa = ia;
        longint sb = ib;
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0] p;
        case (op)
            T_MULU:   begin p = ua * ub;            return p[31:0];  end
            T_MULHS:  begin p = sa * sb;            return p[63:32]; end
            T_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
            T_MULHU:  begin p = ua * ub;            return p[63:32]; end
            T_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            T_REMU:   return (b == 0) ? a : a % b;
            T_DIVS: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            T_REMS: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if ((op == T_DIVU || op == T_DIVS || op == T_REMU || op == T_REMS) && b == 0) return 2;
`endif
        return 35;
    endfunction

    // Issue one op at the next falling edge (cycle 0) and follow it to done_o
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int cyc;
        int lat;
        logic stall_bad;
        logic [31:0] res;
        @(negedge clk);
        start_i  = 1'b1;
        alu_op_i = op;
        a_i      = a;
        b_i      = b;
        #1;
        cyc = 0;
        lat = -1;
        stall_bad = (stall_o !== 1'b1);
        res = 'x;
        while (lat < 0 && cyc < 200) begin
            @(negedge clk);
            start_i = 1'b0;
            a_i = $urandom;
            b_i = $urandom;
            #1;
            cyc++;
            if (done_o === 1'b1) begin
                lat = cyc;
                res = result_o;
                if (stall_o !== 1'b0) stall_bad = 1'b1;
            end else if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        $display("op=%b a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, res, exp, lat);
        if (lat < 0) begin
            check("timeout", 32'd1, 32'd0);
        end else begin
            check("result", res, exp);
            check("latency", lat, exp_latency(op, b));
            check("stall_profile", {31'b0, stall_bad}, 32'd0);
            @(negedge clk);
            #1;
            check("done_pulse_width", {31'b0, done_o}, 32'd0);
            check("idle_after_done", {31'b0, busy_o}, 32'd0);
            check("result_hold", result_o, exp);
        end
    endtask

    logic [4:0]  op_list [8];
    logic [31:0] corner  [6];

    initial begin
        logic [4:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic        seen_done;

        op_list = '{T_MULU, T_MULHS, T_MULHSU, T_MULHU, T_DIVU, T_DIVS, T_REMU, T_REMS};
        corner  = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

        vecs.push_back(vec_t'{T_MULU,   32'd7,        32'd6,        32'd42});
        vecs.push_back(vec_t'{T_MULHS,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back(vec_t'{T_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back(vec_t'{T_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF});
        vecs.push_back(vec_t'{T_MULU,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back(vec_t'{T_MULHS,  32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back(vec_t'{T_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back(vec_t'{T_DIVS,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back(vec_t'{T_REMS,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back(vec_t'{T_DIVS,   32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back(vec_t'{T_REMS,   32'h80000000, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back(vec_t'{T_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF});
        vecs.push_back(vec_t'{T_REMU,   32'd5,        32'd0,        32'd5});
        vecs.push_back(vec_t'{T_DIVS,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF});
        vecs.push_back(vec_t'{T_REMS,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});
        vecs.push_back(vec_t'{T_DIVU,   32'd100,      32'd7,        32'd14});
        vecs.push_back(vec_t'{T_REMU,   32'd100,      32'd7,        32'd2});

        // Reset state, with an M-op start held high to exercise the stall gate
        start_i  = 1'b1;
        alu_op_i = T_MULU;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy",   {31'b0, busy_o},  32'd0);
        check("reset_done",   {31'b0, done_o},  32'd0);
        check("reset_stall",  {31'b0, stall_o}, 32'd0);
        check("reset_result", result_o,         32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Non-M op (add) is ignored
        @(negedge clk);
        start_i  = 1'b1;
        alu_op_i = 5'b00010;
        a_i = 32'd3;
        b_i = 32'd4;
        #1;
        check("nonm_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("nonm_busy", {31'b0, busy_o}, 32'd0);
        $display("op=00010 non-M start: stall=%b busy=%b", stall_o, busy_o);

        // Flush in cycle 10 of a divu, new op in cycle 12
        @(negedge clk);
        start_i  = 1'b1;
        alu_op_i = T_DIVU;
        a_i = 32'd1000;
        b_i = 32'd3;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (done_o === 1'b1) seen_done = 1'b1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        if (done_o === 1'b1) seen_done = 1'b1;
        check("flush_idle", {31'b0, busy_o}, 32'd0);
        check("flush_no_done", {31'b0, seen_done}, 32'd0);
        $display("flush at cycle 10: busy=%b done_seen=%b", busy_o, seen_done);
        run_op(T_MULU, 32'd7, 32'd6, 32'd42);

        // Reset asserted in cycle 20 of a mul
        @(negedge clk);
        start_i  = 1'b1;
        alu_op_i = T_MULU;
        a_i = 32'd3;
        b_i = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst = 1'b0;
        start_i = 1'b1;
        #1;
        check("midreset_busy",   {31'b0, busy_o},  32'd0);
        check("midreset_done",   {31'b0, done_o},  32'd0);
        check("midreset_stall",  {31'b0, stall_o}, 32'd0);
        check("midreset_result", result_o,         32'd0);
        $display("reset at cycle 20: busy=%b done=%b stall=%b result=%h", busy_o, done_o, stall_o, result_o);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        run_op(T_MULHU, 32'h12345678, 32'h9ABCDEF0, ref_model(T_MULHU, 32'h12345678, 32'h9ABCDEF0));

        // Random ops against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            r_op = op_list[$urandom_range(0, 7)];
            r_a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 4) == 0) r_b = r_b >> $urandom_range(8, 31);
            run_op(r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
